// File: rtl/t06_tone_sequencer.sv
// t06_tone_sequencer: looping tone/rest step sequencer with prioritised event phrases
module t06_tone_sequencer #(
    parameter int STEPS    = 32,
    parameter int EV_N     = 2,
    parameter int EV_STEPS = 2,
    parameter int PRESCALE = 50000,
    parameter int LEN_W    = 19,
    parameter int TONE_LEN = 25,
    parameter int REST_LEN = 30,
    parameter int EV_LEN   = 31,
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int EW = (EV_N > 1) ? $clog2(EV_N) : 1,
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [EV_N-1:0] event_i,
    output logic [SW-1:0]   step_o,
    output logic            mode_o,
    output logic [EW-1:0]   event_id_o,
    output logic            tone_o,
    output logic            tick_o
);
    typedef enum logic {LOOP, PHRASE} state_t;
    state_t           state_q;
    logic [SW-1:0]    step_q;
    logic [EW-1:0]    ev_q;
    logic [PW-1:0]    pre_q, pre_d;
    logic [LEN_W-1:0] dur_q, dur_d;
    logic [LEN_W-1:0] len;
    logic [EW-1:0]    k;
    logic             tick, step_end, accept;

    assign tick     = enable && (pre_q == PW'(PRESCALE - 1));
    assign len      = (state_q == PHRASE) ? LEN_W'(EV_LEN) : step_q[0] ? LEN_W'(REST_LEN) : LEN_W'(TONE_LEN);
    assign step_end = tick && (dur_q == len - 1'b1);

    // lowest set request bit wins
    always_comb begin
        k = '0;
        for (int i = EV_N - 1; i >= 0; i--)
            if (event_i[i]) k = EW'(i);
    end

    assign accept = enable && (|event_i) && (state_q == LOOP || k <= ev_q);

    // prescaler and duration counter next state; an accepted event restarts both
    always_comb begin
        pre_d = !enable ? pre_q : (accept || tick) ? '0 : pre_q + 1'b1;
        dur_d = !enable ? dur_q : (accept || step_end) ? '0 : tick ? dur_q + 1'b1 : dur_q;
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            dur_q <= '0;
        end else begin
            pre_q <= pre_d;
            dur_q <= dur_d;
        end
    end

    // loop/phrase state machine; an event accept overrides a coincident step end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOP;
            step_q  <= '0;
            ev_q    <= '0;
        end else if (accept) begin
            state_q <= PHRASE;
            step_q  <= '0;
            ev_q    <= k;
        end else if (step_end) begin
            if (state_q == PHRASE && step_q == SW'(EV_STEPS - 1)) begin
                state_q <= LOOP;
                step_q  <= '0;
            end else if (state_q == LOOP && step_q == SW'(STEPS - 1)) begin
                step_q  <= '0;
            end else begin
                step_q  <= step_q + 1'b1;
            end
        end
    end

    assign step_o     = step_q;
    assign mode_o     = (state_q == PHRASE);
    assign event_id_o = ev_q;
    assign tone_o     = enable && !step_q[0];
    assign tick_o     = tick;
endmodule

// File: tb/tb_t06_tone_sequencer.sv
// tb_t06_tone_sequencer: vector table, directed corner sequences and random run against a cycle-count model
module tb_t06_tone_sequencer;
    localparam int STEPS = 4, EV_N = 2, EV_STEPS = 2, PRESCALE = 4;
    localparam int TONE_LEN = 2, REST_LEN = 3, EV_LEN = 1;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [1:0] event_i;
    logic [1:0] step_o;
    logic       mode_o, tone_o, tick_o;
    logic [0:0] event_id_o;

    t06_tone_sequencer #(
        .STEPS(STEPS), .EV_N(EV_N), .EV_STEPS(EV_STEPS), .PRESCALE(PRESCALE),
        .LEN_W(19), .TONE_LEN(TONE_LEN), .REST_LEN(REST_LEN), .EV_LEN(EV_LEN)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .event_i(event_i),
        .step_o(step_o), .mode_o(mode_o), .event_id_o(event_id_o),
        .tone_o(tone_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    logic last_tick;

    // reference: position within a step is a count of enabled cycles since the step began
    int m_step, m_mode, m_id, m_e;

    function automatic int step_cycles();
        int l;
        l = m_mode ? EV_LEN : (m_step % 2) ? REST_LEN : TONE_LEN;
        return l * PRESCALE;
    endfunction

    function automatic logic [5:0] model_out(input logic en);
        logic [1:0] s;
        logic       id;
        s  = 2'(m_step);
        id = 1'(m_id);
        return {s, m_mode[0], id, en && (m_step % 2 == 0), en && (m_e % PRESCALE == PRESCALE - 1)};
    endfunction

    task automatic model_update(input logic r, input logic en, input logic [1:0] ev);
        int k;
        if (r) begin
            m_step = 0; m_mode = 0; m_id = 0; m_e = 0;
        end else if (en) begin
            k = -1;
            for (int i = EV_N - 1; i >= 0; i--) if (ev[i]) k = i;
            if (k >= 0 && (m_mode == 0 || k <= m_id)) begin
                m_mode = 1; m_id = k; m_step = 0; m_e = 0;
            end else begin
                m_e++;
                if (m_e == step_cycles()) begin
                    m_e = 0;
                    if (m_mode == 1 && m_step == EV_STEPS - 1) begin
                        m_mode = 0; m_step = 0;
                    end else if (m_mode == 0) m_step = (m_step + 1) % STEPS;
                    else m_step++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // one clock cycle: drive inputs, compare outputs with the model, advance both
    task automatic apply(input logic r, input logic en, input logic [1:0] ev);
        rst = r; enable = en; event_i = ev;
        #1;
        last_tick = tick_o;
        chk("model {step,mode,id,tone,tick}", int'({step_o, mode_o, event_id_o, tone_o, tick_o}), int'(model_out(en)));
        @(posedge clk);
        model_update(r, en, ev);
        @(negedge clk);
    endtask

    task automatic run_until_change(output int n);
        logic [1:0] s0;
        s0 = step_o;
        n = 0;
        do begin
            apply(1'b0, 1'b1, 2'b00);
            n++;
        end while (step_o == s0 && n < 200);
    endtask

    typedef struct {
        logic       r, en;
        logic [1:0] ev;
        logic [1:0] step;
        logic       mode, id, tone, tick;
    } vec_t;
    vec_t vt[18];

    initial begin
        int n, n2, sum;
        vt[0]  = '{0,1,2'b00, 0,0,0,1,0};
        vt[1]  = '{0,1,2'b00, 0,0,0,1,0};
        vt[2]  = '{0,1,2'b00, 0,0,0,1,0};
        vt[3]  = '{0,1,2'b00, 0,0,0,1,1};
        vt[4]  = '{0,0,2'b00, 0,0,0,0,0};
        vt[5]  = '{0,1,2'b10, 0,0,0,1,0};
        vt[6]  = '{0,1,2'b01, 0,1,1,1,0};
        vt[7]  = '{0,1,2'b10, 0,1,0,1,0};
        vt[8]  = '{0,1,2'b00, 0,1,0,1,0};
        vt[9]  = '{0,1,2'b00, 0,1,0,1,0};
        vt[10] = '{0,1,2'b00, 0,1,0,1,1};
        vt[11] = '{0,1,2'b00, 1,1,0,0,0};
        vt[12] = '{0,1,2'b00, 1,1,0,0,0};
        vt[13] = '{0,1,2'b00, 1,1,0,0,0};
        vt[14] = '{0,1,2'b00, 1,1,0,0,1};
        vt[15] = '{0,1,2'b00, 0,0,0,1,0};
        vt[16] = '{1,1,2'b00, 0,0,0,1,0};
        vt[17] = '{0,0,2'b00, 0,0,0,0,0};

        rst = 1'b1; enable = 1'b0; event_i = 2'b00;
        @(posedge clk);
        model_update(1'b1, 1'b0, 2'b00);
        @(negedge clk);

        foreach (vt[i]) begin
            rst = vt[i].r; enable = vt[i].en; event_i = vt[i].ev;
            #1;
            chk($sformatf("vec%0d", i), int'({step_o, mode_o, event_id_o, tone_o, tick_o}),
                int'({vt[i].step, vt[i].mode, vt[i].id, vt[i].tone, vt[i].tick}));
            apply(vt[i].r, vt[i].en, vt[i].ev);
        end

        // free run from reset: 8/12/8/12 cycles, wrap after 40
        apply(1'b1, 1'b1, 2'b00);
        sum = 0;
        for (int s = 0; s < STEPS; s++) begin
            chk($sformatf("free step %0d index", s), step_o, s);
            run_until_change(n);
            chk($sformatf("free step %0d cycles", s), n, (s % 2) ? 12 : 8);
            sum += n;
        end
        chk("loop period", sum, 40);
        chk("wrap to step 0", step_o, 0);

        // pause for 10 cycles inside step 1
        run_until_change(n);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 10; i++) begin
            rst = 1'b0; enable = 1'b0; event_i = 2'b11;
            #1;
            chk("pause tone/tick", int'({tone_o, tick_o}), 0);
            apply(1'b0, 1'b0, 2'b11);
        end
        run_until_change(n2);
        chk("paused step 1 cycles", 15 + n2, 22);

        // event phrase from loop step 2
        chk("at step 2", step_o, 2);
        apply(1'b0, 1'b1, 2'b00);
        apply(1'b0, 1'b1, 2'b00);
        apply(1'b0, 1'b1, 2'b10);
        chk("event accept", int'({mode_o, event_id_o, step_o}), 3'b110 << 1);
        run_until_change(n);
        chk("phrase step 0 cycles", n, 4);
        chk("phrase step 1", int'({mode_o, step_o}), 3'b101);
        run_until_change(n);
        chk("phrase step 1 cycles", n, 4);
        chk("return to loop", int'({mode_o, step_o}), 0);

        // event on the loop step-end tick wins
        for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 2'b00);
        apply(1'b0, 1'b1, 2'b01);
        chk("collision accept", int'({mode_o, event_id_o, step_o}), 4'b1000);
        apply(1'b0, 1'b1, 2'b10);
        chk("lower priority ignored", int'({mode_o, event_id_o}), 2'b10);
        run_until_change(n);
        chk("id0 phrase unchanged", n, 3);
        run_until_change(n);
        apply(1'b0, 1'b1, 2'b11);
        chk("both bits pick id0", int'({mode_o, event_id_o}), 2'b10);
        run_until_change(n);
        run_until_change(n);
        apply(1'b0, 1'b1, 2'b10);
        chk("id1 phrase", int'({mode_o, event_id_o}), 2'b11);
        apply(1'b0, 1'b1, 2'b00);
        apply(1'b0, 1'b1, 2'b01);
        chk("id0 preempts id1", int'({mode_o, event_id_o, step_o}), 4'b1000);
        run_until_change(n);
        chk("preempted phrase full length", n, 4);
        run_until_change(n);
        apply(1'b0, 1'b0, 2'b01);
        chk("event dropped while disabled", mode_o, 0);

        // reset during event step 1
        apply(1'b0, 1'b1, 2'b10);
        run_until_change(n);
        chk("in event step 1", int'({mode_o, step_o}), 3'b101);
        apply(1'b1, 1'b1, 2'b00);
        chk("reset mid-phrase", int'({step_o, mode_o, event_id_o}), 0);
        n = 0;
        do begin
            apply(1'b0, 1'b1, 2'b00);
            n++;
        end while (!last_tick && n < 20);
        chk("first tick after reset", n, 4);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ev;
            ev = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, ev);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
